// File: rtl/csa_sub_seq_if.sv
// Request/result handshake bundle for the sequential carry-select subtractor.
// Signal names are seen from the subtractor's side of the link.
interface csa_sub_seq_if #(
  parameter int WIDTH = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_sub_term1;
  logic [WIDTH-1:0] i_sub_term2;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport slave (
    input  i_valid, i_sub_term1, i_sub_term2, i_ready,
    output o_ready, o_valid, diff, bout, ovf
  );

  modport master (
    output i_valid, i_sub_term1, i_sub_term2, i_ready,
    input  o_ready, o_valid, diff, bout, ovf
  );
endinterface

// File: rtl/csa_sub_seq.sv
// Multi-cycle subtractor: DIFF = A - B, one 4-bit carry-select slice per clock, LSB slice first.
// state | meaning
// IDLE  | waiting for a request, o_ready=1
// RUN   | processing slice idx_q, one per edge
// DONE  | result held on diff/bout/ovf until i_ready
module csa_sub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  csa_sub_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bn_q, bn_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  int unsigned      base;
  logic [SLICE-1:0] a_sl, bn_sl;
  logic [SLICE:0]   s0, s1, sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      bn_q    <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b1;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bn_q    <= bn_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bn_d    = bn_q;
    diff_d  = diff_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    // Both carry-in variants are formed; the stored inter-slice carry picks one.
    base  = int'(idx_q) * SLICE;
    a_sl  = a_q[base +: SLICE];
    bn_sl = bn_q[base +: SLICE];
    s0    = {1'b0, a_sl} + {1'b0, bn_sl};
    s1    = s0 + (SLICE+1)'(1);
    sel   = carry_q ? s1 : s0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_sub_term1;
          bn_d    = ~bus.i_sub_term2;
          carry_d = 1'b1;
          idx_d   = '0;
          diff_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[base +: SLICE] = sel[SLICE-1:0];
        carry_d = sel[SLICE];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NSLICE - 1)) begin
          state_d = DONE;
          bout_d  = ~sel[SLICE];
          // Operand signs differ (bn holds ~B) and result sign differs from A.
          ovf_d   = (a_q[WIDTH-1] == bn_q[WIDTH-1]) && (sel[SLICE-1] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.diff    = diff_q;
  assign bus.bout    = bout_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_csa_sub_seq.sv
// Randomized and directed bench for csa_sub_seq against an arithmetic reference model.
module tb_csa_sub_seq;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  csa_sub_seq_if #(.WIDTH(WIDTH)) bus();

  csa_sub_seq #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] d, output logic bo, output logic ov);
    int sd;
    d  = a - b;
    bo = (a < b);
    sd = int'($signed(a)) - int'($signed(b));
    ov = (sd > 32767) || (sd < -32768);
  endfunction

  task automatic scramble();
    bus.i_valid     = 1'($urandom_range(0, 1));
    bus.i_sub_term1 = 16'($urandom);
    bus.i_sub_term2 = 16'($urandom);
  endtask

  // Caller is #1 after an edge with the block idle and i_ready low.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    int         lat;
    logic [15:0] ed, held;
    logic        eb, eo;
    model(a, b, ed, eb, eo);
    chk("ready_pre", 32'(bus.o_ready), 32'd1);
    bus.i_valid     = 1'b1;
    bus.i_sub_term1 = a;
    bus.i_sub_term2 = b;
    @(posedge clk); #1;
    lat = 0;
    while (!bus.o_valid && lat < 20) begin
      chk("ready_busy", 32'(bus.o_ready), 32'd0);
      scramble();
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(NSLICE));
    chk("diff", 32'(bus.diff), 32'(ed));
    chk("bout", 32'(bus.bout), 32'(eb));
    chk("ovf", 32'(bus.ovf), 32'(eo));
    held = bus.diff;
    for (int i = 0; i < hold; i++) begin
      scramble();
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.o_valid), 32'd1);
      chk("hold_ready", 32'(bus.o_ready), 32'd0);
      chk("hold_diff", 32'(bus.diff), 32'(held));
      chk("hold_flags", {30'd0, bus.bout, bus.ovf}, {30'd0, eb, eo});
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk("retire_ready", 32'(bus.o_ready), 32'd1);
    chk("retire_valid", 32'(bus.o_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb, ed;
    logic        eb, eo;
    int          guard, cyc, prev;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_sub_term1 = '0;
    bus.i_sub_term2 = '0;
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_flags", {30'd0, bus.bout, bus.ovf}, 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0234, 0);
    run_op(16'h0000, 16'h0001, 0);
    run_op(16'h1000, 16'h0001, 0);
    run_op(16'h8000, 16'h0001, 0);
    run_op(16'h7FFF, 16'hFFFF, 0);
    run_op(16'hABCD, 16'h1357, 3);

    // Abort mid-RUN with an asynchronous reset.
    bus.i_valid = 1'b1;
    bus.i_sub_term1 = 16'h5555;
    bus.i_sub_term2 = 16'h1111;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.o_valid), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'hFFFF, 16'hFFFF, 0);

    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end
    run_op(16'h8000, 16'h7FFF, 1);
    run_op(16'hFFFF, 16'h0000, 0);

    // Continuous traffic: one accept every NSLICE+2 edges.
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    cyc = 0;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      bus.i_sub_term1 = ra;
      bus.i_sub_term2 = rb;
      guard = 0;
      while (!bus.o_ready && guard < 20) begin
        @(posedge clk); #1;
        cyc++;
        guard++;
      end
      chk("b2b_ready_wait", 32'(guard < 20), 32'd1);
      @(posedge clk); #1;
      cyc++;
      if (k > 0) chk("b2b_gap", 32'(cyc - prev), 32'(NSLICE + 2));
      prev = cyc;
      bus.i_sub_term1 = 16'($urandom);
      bus.i_sub_term2 = 16'($urandom);
      guard = 0;
      while (!bus.o_valid && guard < 20) begin
        @(posedge clk); #1;
        cyc++;
        guard++;
      end
      model(ra, rb, ed, eb, eo);
      chk("b2b_diff", 32'(bus.diff), 32'(ed));
      chk("b2b_flags", {30'd0, bus.bout, bus.ovf}, {30'd0, eb, eo});
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
